vip_stream_encoder: RTL and testbench

- Output-side counterpart of the user algorithm core, and the "VIP control packet encoder" it drives.
- Accepts the algorithm's flow-controlled pixel beats and its control-packet send requests (width/height/interlaced).
- Serialises them onto an Avalon-ST video output as VIP control packets (type 0xF) and video packets (type 0x0), with sop/eop framing and ready/valid backpressure.
- Sits between the algorithm core and the downstream VIP sink (frame buffer / CVO).

---
 rtl/vip_pkg.sv | 22 ++
 rtl/vip_stream_encoder_if.sv | 20 ++
 rtl/vip_enc_fifo.sv | 51 +++++
 rtl/vip_stream_encoder.sv | 174 +++++++++++++++++
 tb/tb_vip_stream_encoder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vip_pkg.sv
// Shared definitions for the VIP stream encoder: packet type codes, control
// packet geometry and the encoder state set.
package vip_pkg;

  localparam logic [3:0]  VIP_TYPE_VIDEO = 4'h0;
  localparam logic [3:0]  VIP_TYPE_CTRL  = 4'hF;
  localparam int unsigned CTRL_NIBBLES   = 9;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HDR,
    CTRL_DATA,
    VID_HDR,
    VID_DATA
  } state_t;

  // Beats needed to carry the control nibbles at the given beat width.
  function automatic int unsigned ctrl_beats(input int unsigned symbols_per_beat);
    return (CTRL_NIBBLES + symbols_per_beat - 1) / symbols_per_beat;
  endfunction

endpackage

// File: rtl/vip_stream_encoder_if.sv
// Avalon-ST video output bundle (ready latency 0).
interface vip_stream_encoder_if #(
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              startofpacket;
  logic              endofpacket;

  modport master (
    output data, valid, startofpacket, endofpacket,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket,
    output ready
  );
endinterface

// File: rtl/vip_enc_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on dout whenever not empty.
module vip_enc_fifo #(
  parameter int unsigned WIDTH      = 25,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [WIDTH-1:0]                din,
  input  logic                            pop,
  output logic [WIDTH-1:0]                dout,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            full,
  output logic                            empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vip_stream_encoder.sv
// Serialises algorithm pixel beats and control-packet requests onto an
// Avalon-ST VIP output as control (type 0xF) and video (type 0x0) packets.
module vip_stream_encoder
  import vip_pkg::*;
#(
  parameter int unsigned BITS_PER_SYMBOL  = 8,
  parameter int unsigned SYMBOLS_PER_BEAT = 3,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         write,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  data_in,
  input  logic                                         end_of_video,
  output logic                                         stall,
  input  logic [15:0]                                  width_in,
  input  logic [15:0]                                  height_in,
  input  logic [3:0]                                   interlaced_in,
  input  logic                                         vip_ctrl_send,
  output logic                                         vip_ctrl_busy,
  vip_stream_encoder_if.master                         dout
);

  localparam int unsigned DW  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int unsigned NB  = ctrl_beats(SYMBOLS_PER_BEAT);
  localparam logic [3:0]  K_LAST = 4'(NB - 1);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_n;
  logic [3:0]    k, k_n;
  logic          take_pending;

  logic          pending;
  logic [15:0]   pend_w, pend_h, act_w, act_h;
  logic [3:0]    pend_il, act_il;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          head_eov;
  logic [DW-1:0] head_data;

  logic [35:0]   ctrl_nibbles;
  logic [DW-1:0] ctrl_data;

  logic          out_valid, out_sop, out_eop;
  logic [DW-1:0] out_data;

  assign stall     = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_push = write & ~fifo_full;
  assign {head_eov, head_data} = fifo_head;

  vip_enc_fifo #(
    .WIDTH      (DW + 1),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({end_of_video, data_in}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign vip_ctrl_busy = pending | (state == CTRL_HDR) | (state == CTRL_DATA);

  // Nibble 0 (width[15:12]) sits in the top of the vector.
  assign ctrl_nibbles = {act_w, act_h, act_il};

  always_comb begin
    int unsigned n;
    n         = 0;
    ctrl_data = '0;
    for (int unsigned s = 0; s < SYMBOLS_PER_BEAT; s++) begin
      n = 32'(k) * SYMBOLS_PER_BEAT + s;
      if (n < CTRL_NIBBLES)
        ctrl_data[s*BITS_PER_SYMBOL +: 4] = ctrl_nibbles[(CTRL_NIBBLES-1-n)*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      pending <= 1'b0;
      pend_w  <= '0;
      pend_h  <= '0;
      pend_il <= '0;
      act_w   <= '0;
      act_h   <= '0;
      act_il  <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      if (take_pending) begin
        act_w   <= pend_w;
        act_h   <= pend_h;
        act_il  <= pend_il;
        pending <= 1'b0;
      end
      // A new request arriving as the old one is taken wins the pending flag.
      if (vip_ctrl_send) begin
        pend_w  <= width_in;
        pend_h  <= height_in;
        pend_il <= interlaced_in;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    k_n          = k;
    take_pending = 1'b0;
    fifo_pop     = 1'b0;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_data     = '0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_n      = CTRL_HDR;
          take_pending = 1'b1;
        end else if (!fifo_empty) begin
          state_n = VID_HDR;
        end
      end
      CTRL_HDR: begin
        out_valid     = 1'b1;
        out_sop       = 1'b1;
        out_data[3:0] = VIP_TYPE_CTRL;
        if (dout.ready) begin
          state_n = CTRL_DATA;
          k_n     = '0;
        end
      end
      CTRL_DATA: begin
        out_valid = 1'b1;
        out_data  = ctrl_data;
        out_eop   = (k == K_LAST);
        if (dout.ready) begin
          if (k == K_LAST) state_n = IDLE;
          else             k_n     = k + 1'b1;
        end
      end
      VID_HDR: begin
        out_valid     = 1'b1;
        out_sop       = 1'b1;
        out_data[3:0] = VIP_TYPE_VIDEO;
        if (dout.ready) state_n = VID_DATA;
      end
      VID_DATA: begin
        out_valid = ~fifo_empty;
        out_data  = head_data;
        out_eop   = head_eov & ~fifo_empty;
        if (!fifo_empty && dout.ready) begin
          fifo_pop = 1'b1;
          if (head_eov) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign dout.valid         = out_valid;
  assign dout.data          = out_data;
  assign dout.startofpacket = out_sop;
  assign dout.endofpacket   = out_eop;

endmodule

// File: tb/tb_vip_stream_encoder.sv
// Directed self-checking bench for vip_stream_encoder (8-bit x 3 symbols, FIFO depth 4).
module tb_vip_stream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [23:0] data_in;
  logic        end_of_video;
  logic        stall;
  logic [15:0] width_in;
  logic [15:0] height_in;
  logic [3:0]  interlaced_in;
  logic        vip_ctrl_send;
  logic        vip_ctrl_busy;
  logic        rdy;

  vip_stream_encoder_if #(.DATA_W(24)) dout_if ();
  assign dout_if.ready = rdy;

  vip_stream_encoder #(
    .BITS_PER_SYMBOL  (8),
    .SYMBOLS_PER_BEAT (3),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .write         (write),
    .data_in       (data_in),
    .end_of_video  (end_of_video),
    .stall         (stall),
    .width_in      (width_in),
    .height_in     (height_in),
    .interlaced_in (interlaced_in),
    .vip_ctrl_send (vip_ctrl_send),
    .vip_ctrl_busy (vip_ctrl_busy),
    .dout          (dout_if.master)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [24:0] src[$];     // {end_of_video, data}
  logic [26:0] out_q[$];   // {valid, sop, eop, data}
  logic        send_req = 1'b0;
  logic        hold_chk = 1'b0;
  logic [26:0] held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] beat(input logic sop, input logic eop, input logic [23:0] d);
    return {1'b1, sop, eop, d};
  endfunction

  // One clock: drive inputs, log the beat that transfers on the coming edge,
  // then advance to 1 time unit past the edge.
  task automatic step();
    logic        acc;
    logic [26:0] cur;
    vip_ctrl_send = send_req;
    if (src.size() > 0) begin
      write = 1'b1;
      {end_of_video, data_in} = src[0];
    end else begin
      write = 1'b0;
      end_of_video = 1'b0;
      data_in = '0;
    end
    cur = {dout_if.valid, dout_if.startofpacket, dout_if.endofpacket, dout_if.data};
    if (hold_chk && !rst) check("hold_stable", 32'(cur), 32'(held));
    acc = write && !stall && !rst;
    if (dout_if.valid && rdy) out_q.push_back(cur);
    hold_chk = dout_if.valid && !rdy && !rst;
    held = cur;
    @(posedge clk);
    #1;
    if (acc) void'(src.pop_front());
    send_req = 1'b0;
  endtask

  task automatic run_until(input int unsigned n, input int unsigned max_cyc, input string tag);
    int unsigned g = 0;
    while (out_q.size() < n && g < max_cyc) begin
      step();
      g++;
    end
    check(tag, 32'(out_q.size()), 32'(n));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic check_beats(input string tag, input logic [26:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < out_q.size()) check($sformatf("%s[%0d]", tag, i), 32'(out_q[i]), 32'(exp[i]));
      else                  check($sformatf("%s[%0d]_missing", tag, i), 32'(0), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [26:0] exp[$];
    int unsigned g;

    rst = 1'b1; rdy = 1'b1;
    width_in = '0; height_in = '0; interlaced_in = '0;
    write = 1'b0; data_in = '0; end_of_video = 1'b0; vip_ctrl_send = 1'b0;
    idle(2);

    // Reset state
    check("rst_valid", 32'(dout_if.valid), 0);
    check("rst_sop",   32'(dout_if.startofpacket), 0);
    check("rst_eop",   32'(dout_if.endofpacket), 0);
    check("rst_data",  32'(dout_if.data), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_busy",  32'(vip_ctrl_busy), 0);
    rst = 1'b0;
    idle(1);

    // Control packet 640x480, progressive
    width_in = 16'd640; height_in = 16'd480; interlaced_in = 4'd0;
    send_req = 1'b1;
    step();
    g = 0;
    while (out_q.size() < 4 && g < 20) begin
      check("ctrl_busy_high", 32'(vip_ctrl_busy), 1);
      step();
      g++;
    end
    check("ctrl_count", 32'(out_q.size()), 4);
    check("ctrl_busy_low", 32'(vip_ctrl_busy), 0);
    exp = '{beat(1,0,24'h00000F), beat(0,0,24'h080200), beat(0,0,24'h010000), beat(0,1,24'h00000E)};
    check_beats("ctrl640", exp);
    out_q.delete();
    idle(2);

    // 8-pixel video frame
    for (int i = 1; i <= 8; i++)
      src.push_back({(i == 8), 8'(i), 8'(i + 1), 8'(i + 2)});
    run_until(9, 40, "vid8_count");
    exp = '{beat(1,0,24'h000000)};
    for (int i = 1; i <= 8; i++)
      exp.push_back(beat(0, (i == 8), {8'(i), 8'(i + 1), 8'(i + 2)}));
    check_beats("vid8", exp);
    check("vid8_idle_valid", 32'(dout_if.valid), 0);
    out_q.delete();
    idle(2);

    // Backpressure: FIFO fills, fifth pixel held
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) src.push_back({(i == 5), 24'hA0A0A0 + 24'(i)});
    idle(10);
    check("bp_stall", 32'(stall), 1);
    check("bp_held", 32'(src.size()), 1);
    check("bp_hdr_waiting", 32'(dout_if.valid), 1);
    rdy = 1'b1;
    run_until(6, 40, "bp_count");
    exp = '{beat(1,0,24'h000000)};
    for (int i = 1; i <= 5; i++) exp.push_back(beat(0, (i == 5), 24'hA0A0A0 + 24'(i)));
    check_beats("bp", exp);
    check("bp_stall_clear", 32'(stall), 0);
    out_q.delete();
    idle(2);

    // Send during VID_DATA: serviced only after the video eop
    for (int i = 1; i <= 4; i++) src.push_back({(i == 4), 24'h111111 * 24'(i)});
    g = 0;
    while (out_q.size() < 2 && g < 20) begin step(); g++; end
    width_in = 16'h0010; height_in = 16'h0020; interlaced_in = 4'h3;
    send_req = 1'b1;
    step();
    check("mid_busy", 32'(vip_ctrl_busy), 1);
    run_until(9, 40, "mid_count");
    exp = '{beat(1,0,24'h000000)};
    for (int i = 1; i <= 4; i++) exp.push_back(beat(0, (i == 4), 24'h111111 * 24'(i)));
    exp.push_back(beat(1,0,24'h00000F));
    exp.push_back(beat(0,0,24'h010000));
    exp.push_back(beat(0,0,24'h000000));
    exp.push_back(beat(0,1,24'h030002));
    check_beats("mid", exp);
    check("mid_busy_low", 32'(vip_ctrl_busy), 0);
    out_q.delete();
    idle(2);

    // Two sends before service: last one wins, single packet
    rdy = 1'b0;
    src.push_back({1'b1, 24'h123456});
    idle(4);
    width_in = 16'd640; height_in = 16'd480; interlaced_in = 4'd0;
    send_req = 1'b1;
    step();
    width_in = 16'd1280; height_in = 16'd720; interlaced_in = 4'd0;
    send_req = 1'b1;
    step();
    rdy = 1'b1;
    run_until(6, 40, "dbl_count");
    exp = '{beat(1,0,24'h000000), beat(0,1,24'h123456),
            beat(1,0,24'h00000F), beat(0,0,24'h000500),
            beat(0,0,24'h020000), beat(0,1,24'h00000D)};
    check_beats("dbl", exp);
    idle(6);
    check("dbl_no_extra", 32'(out_q.size()), 6);
    check("dbl_busy_low", 32'(vip_ctrl_busy), 0);
    out_q.delete();

    // Reset mid-frame
    for (int i = 1; i <= 8; i++) src.push_back({(i == 8), 24'h200000 + 24'(i)});
    run_until(4, 40, "rstmid_pre");
    width_in = 16'd64; height_in = 16'd32;
    send_req = 1'b1;
    step();
    src.delete();
    rst = 1'b1;
    step();
    check("rstmid_valid", 32'(dout_if.valid), 0);
    check("rstmid_eop",   32'(dout_if.endofpacket), 0);
    check("rstmid_stall", 32'(stall), 0);
    check("rstmid_busy",  32'(vip_ctrl_busy), 0);
    rst = 1'b0;
    out_q.delete();
    idle(4);
    check("rstmid_flushed", 32'(out_q.size()), 0);
    src.push_back({1'b0, 24'hC0FFEE});
    src.push_back({1'b1, 24'hBADA55});
    run_until(3, 40, "rstmid_new_count");
    exp = '{beat(1,0,24'h000000), beat(0,0,24'hC0FFEE), beat(0,1,24'hBADA55)};
    check_beats("rstmid_new", exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
